// File: rtl/led_key_ctrl.sv
// Debounced key toggles driving logic/toggle/blink/chase LED modes; led_out is registered one edge after sampling.
// Define LED_BLINK_EN to build the prescaler, blink phase and chase ring; without it modes 2/3 show tog.
module led_key_ctrl #(
  parameter int CH           = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int BLINK_DIV    = 25_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] a,
  input  logic [CH-1:0] b,
  input  logic [CH-1:0] key_in,
  input  logic [1:0]    mode,
  output logic [CH-1:0] led_out
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic [CH-1:0]         key_meta;
  logic [CH-1:0]         key_s;
  logic [CH-1:0]         key_db;
  logic [CH-1:0]         tog;
  logic [CH-1:0][DW-1:0] db_cnt;

  // Keys idle high, so synchronisers and debounced level reset to "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= '1;
      key_s    <= '1;
      key_db   <= '1;
      tog      <= '0;
      db_cnt   <= '0;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
      for (int i = 0; i < CH; i++) begin
        if (key_s[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          key_db[i] <= key_s[i];
          if (!key_s[i]) begin
            tog[i] <= ~tog[i];
          end
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef LED_BLINK_EN
  localparam int PW = $clog2(BLINK_DIV);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          phase;
  logic [CH-1:0] chase;

  assign tick = (pre_cnt == PW'(BLINK_DIV - 1));

  // Rotate-left written as shift/or so a single channel keeps its one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      phase   <= 1'b0;
      chase   <= CH'(1);
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) begin
        phase <= ~phase;
        chase <= (chase << 1) | (chase >> (CH - 1));
      end
    end
  end
`else
  logic [31:0] unused_blink_div;
  assign unused_blink_div = 32'(BLINK_DIV);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else begin
      case (mode)
        2'd0:    led_out <= (a ^ b) & ~key_db;
`ifdef LED_BLINK_EN
        2'd2:    led_out <= tog & {CH{phase}};
        2'd3:    led_out <= chase;
`endif
        default: led_out <= tog;
      endcase
    end
  end
endmodule

// File: tb/tb_led_key_ctrl.sv
// Bench for led_key_ctrl: per-cycle comparison against a window-based behavioural model plus hand-timed literal checks.
module tb_led_key_ctrl;
  localparam int CH = 4;
  localparam int DB = 4;
  localparam int BD = 8;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b1;
  logic [CH-1:0] a      = '0;
  logic [CH-1:0] b      = '0;
  logic [CH-1:0] key_in = '1;
  logic [1:0]    mode   = '0;
  logic [CH-1:0] led_out;

  int n_chk  = 0;
  int n_pass = 0;
  int ecnt   = 0;

  logic [CH-1:0] m_db  = '1;
  logic [CH-1:0] m_tog = '0;
  logic [CH-1:0] m_led = '0;
  logic [CH-1:0] kh [$];
  int            m_n   = 0;

  led_key_ctrl #(.CH(CH), .DEBOUNCE_CYC(DB), .BLINK_DIV(BD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .key_in (key_in),
    .mode   (mode),
    .led_out(led_out)
  );

  initial forever #5 clk = ~clk;

  // Expected LED word from the pre-edge view: n edges since reset gives n/BD ticks.
  function automatic logic [CH-1:0] model_out(logic [1:0] md, logic [CH-1:0] av, logic [CH-1:0] bv,
                                              logic [CH-1:0] db, logic [CH-1:0] tg, int n);
`ifdef LED_BLINK_EN
    logic [CH-1:0] ph;
    logic [CH-1:0] ring;
    int            t;
    t    = n / BD;
    ph   = (t % 2 == 1) ? '1 : '0;
    ring = '0;
    ring[t % CH] = 1'b1;
`endif
    case (md)
      2'd0:    return (av ^ bv) & ~db;
`ifdef LED_BLINK_EN
      2'd2:    return tg & ph;
      2'd3:    return ring;
`endif
      default: return tg;
    endcase
  endfunction

  function automatic logic [CH-1:0] bl(logic [CH-1:0] on_val, logic [CH-1:0] off_val);
`ifdef LED_BLINK_EN
    return on_val;
`else
    return off_val;
`endif
  endfunction

  // kh[j] holds key_in sampled j+1 edges ago; the synchronised level at this edge is kh[1].
  initial forever begin : model
    logic [CH-1:0] nxt;
    logic [CH-1:0] hv;
    bit            diff;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      kh.delete();
      for (int j = 0; j < DB + 2; j++) kh.push_back('1);
      m_db  = '1;
      m_tog = '0;
      m_led = '0;
      m_n   = 0;
    end else begin
      m_led = model_out(mode, a, b, m_db, m_tog, m_n);
      nxt = m_db;
      for (int i = 0; i < CH; i++) begin
        diff = 1'b1;
        for (int w = 0; w < DB; w++) begin
          hv = kh[w + 1];
          if (hv[i] == m_db[i]) diff = 1'b0;
        end
        if (diff) begin
          nxt[i] = ~m_db[i];
          if (m_db[i]) m_tog[i] = ~m_tog[i];
        end
      end
      m_db = nxt;
      kh.push_front(key_in);
      void'(kh.pop_back());
      m_n++;
    end
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) ecnt = 0;
    else ecnt++;
  end

  initial forever begin
    @(negedge clk);
    n_chk++;
    if (led_out === m_led) n_pass++;
    else $display("FAIL model edge=%0d led_out=%b expected=%b", ecnt, led_out, m_led);
  end

  task automatic chk(string nm, logic [CH-1:0] exp);
    n_chk++;
    if (led_out === exp) n_pass++;
    else $display("FAIL %s led_out=%b expected=%b", nm, led_out, exp);
  endtask

  task automatic at_edge(int e, logic [CH-1:0] exp, string nm);
    for (int g = 0; g < 2000 && ecnt < e; g++) @(negedge clk);
    n_chk++;
    if (ecnt == e) n_pass++;
    else $display("FAIL %s_edge reached edge %0d expected edge %0d", nm, ecnt, e);
    chk(nm, exp);
  endtask

  task automatic do_reset(logic [1:0] md, logic [CH-1:0] k, logic [CH-1:0] av, logic [CH-1:0] bv);
    @(negedge clk);
    #1;
    rst_n  = 1'b0;
    mode   = md;
    key_in = k;
    a      = av;
    b      = bv;
    @(negedge clk);
    chk("reset", '0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;

    // Logic mode with all keys held from reset, then released.
    do_reset(2'd0, 4'b0000, 4'b0011, 4'b0101);
    at_edge(6, 4'b0000, "logic_pre");
    at_edge(7, 4'b0110, "logic_on");
    key_in = 4'b1111;
    at_edge(13, 4'b0110, "logic_rel_pre");
    at_edge(14, 4'b0000, "logic_rel");

    // Toggle mode: glitch reject, accept, second press, simultaneous presses.
    do_reset(2'd1, 4'b1111, 4'b0000, 4'b0000);
    at_edge(2, 4'b0000, "tog_idle");
    key_in = 4'b1101;
    at_edge(5, 4'b0000, "glitch_in");
    key_in = 4'b1111;
    at_edge(15, 4'b0000, "glitch_reject");
    key_in = 4'b1101;
    at_edge(21, 4'b0000, "press_pre");
    at_edge(22, 4'b0010, "press_on");
    at_edge(25, 4'b0010, "press_hold");
    key_in = 4'b1111;
    at_edge(35, 4'b0010, "release_keep");
    key_in = 4'b1101;
    at_edge(41, 4'b0010, "again_pre");
    at_edge(42, 4'b0000, "again_on");
    at_edge(45, 4'b0000, "again_hold");
    key_in = 4'b1111;
    at_edge(55, 4'b0000, "again_rel");
    key_in = 4'b0110;
    at_edge(61, 4'b0000, "simul_pre");
    at_edge(62, 4'b1001, "simul_on");
    at_edge(65, 4'b1001, "simul_hold");
    key_in = 4'b1111;
    at_edge(75, 4'b1001, "simul_rel");

    // Blink with tog=0010: phase flips at edges 8, 16, 24.
    do_reset(2'd2, 4'b1101, 4'b0000, 4'b0000);
    at_edge(8,  bl(4'b0000, 4'b0010), "blink_0");
    at_edge(9,  4'b0010,              "blink_1");
    at_edge(16, 4'b0010,              "blink_1_end");
    at_edge(17, bl(4'b0000, 4'b0010), "blink_0b");
    at_edge(24, bl(4'b0000, 4'b0010), "blink_0b_end");
    at_edge(25, 4'b0010,              "blink_1b");

    // Chase ring, including a detour through mode 1.
    do_reset(2'd3, 4'b1111, 4'b0000, 4'b0000);
    at_edge(1,  bl(4'b0001, 4'b0000), "chase_0");
    at_edge(8,  bl(4'b0001, 4'b0000), "chase_0_end");
    at_edge(9,  bl(4'b0010, 4'b0000), "chase_1");
    at_edge(17, bl(4'b0100, 4'b0000), "chase_2");
    at_edge(25, bl(4'b1000, 4'b0000), "chase_3");
    at_edge(33, bl(4'b0001, 4'b0000), "chase_wrap");
    mode = 2'd1;
    at_edge(34, 4'b0000, "chase_m1");
    at_edge(36, 4'b0000, "chase_m1_end");
    mode = 2'd3;
    at_edge(37, bl(4'b0001, 4'b0000), "chase_keep");
    at_edge(41, bl(4'b0010, 4'b0000), "chase_resume");

    // tog=1010 through modes 2/3, then async reset mid-count.
    do_reset(2'd1, 4'b0101, 4'b0000, 4'b0000);
    at_edge(6, 4'b0000, "tog2_pre");
    at_edge(7, 4'b1010, "tog2_on");
    mode = 2'd2;
    at_edge(8,  bl(4'b0000, 4'b1010), "m2_a");
    at_edge(12, 4'b1010,              "m2_b");
    at_edge(20, bl(4'b0000, 4'b1010), "m2_c");
    mode = 2'd3;
    at_edge(21, bl(4'b0100, 4'b1010), "m3_a");
    at_edge(25, bl(4'b1000, 4'b1010), "m3_b");
    at_edge(28, bl(4'b1000, 4'b1010), "m3_c");
    #1 rst_n = 1'b0;
    #1 chk("async_rst", 4'b0000);
    key_in = 4'b1111;
    mode   = 2'd1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    at_edge(3, 4'b0000, "tog_cleared");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at edge %0d expected completion", ecnt);
    $fatal(1, "bench did not complete");
  end
endmodule

// File: doc/led_key_ctrl.md
# led_key_ctrl

Parametrised multi-channel LED controller for the board-level LED/key experiments. It takes per-channel operand bits `a`, `b` and raw push-button inputs `key_in`, and adds the sequential behaviour the earlier single-LED gate logic lacks: synchronised, debounced keys; per-channel toggle latches; and a shared prescaler for blink and chase modes. It sits between the board pin wrapper and the LED pins, and all outputs are registered.

## Interface
Parameters:
- `CH`, 4: channel count, 1..32.
- `DEBOUNCE_CYC`, 20: number of consecutive stable clocks needed to accept a key level; must be ≥2.
- `BLINK_DIV`, 25_000_000: clocks per tick for blink and chase; must be ≥2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `a`  in  CH  operand A per channel (synchronous to `clk`).
- `b`  in  CH  operand B per channel (synchronous to `clk`).
- `key_in`  in  CH  raw push buttons, active-low (0 = pressed), asynchronous.
- `mode`  in  2  0 = logic, 1 = toggle, 2 = blink, 3 = chase (synchronous to `clk`).
- `led_out`  out  CH  LED drive, active-high, registered.

## Operation
- **Key path, per channel:** a 2-flop synchroniser produces `s`. A debounce counter of width $clog2(DEBOUNCE_CYC) feeds the debounced level `key_db`.
  - If `s == key_db`, the counter is cleared.
  - Otherwise the counter increments.
  - When `s != key_db` and the counter equals `DEBOUNCE_CYC-1`, `key_db <= s` and the counter clears.
- **Press event:** a press is `key_db` changing 1→0. On that edge, toggle bit `tog[i]` flips. Releases (0→1) have no effect.
- **Multiple keys:** channels are independent, so simultaneous presses on several channels flip each affected bit on the same edge.
- **Prescaler:** counts 0..BLINK_DIV-1 and wraps.
  - `tick` is a single-cycle pulse when the count equals BLINK_DIV-1.
  - `phase` toggles on each tick.
  - The chase register `chase[CH-1:0]` is one-hot and rotates left on each tick, with bit CH-1 wrapping to bit 0. When CH=1 it stays 1.
- **Output mux**, registered into `led_out` every clock:
  - mode 0: `(a ^ b) & ~key_db`, meaning lit while the debounced key is held.
  - mode 1: `tog`.
  - mode 2: `tog & {CH{phase}}`.
  - mode 3: `chase`.
- **Mode change:** takes effect on the next edge. `tog`, the prescaler, `phase` and `chase` are not cleared.
- **Simultaneous press and mode change:** the toggle still applies.

## Timing
- **Reset values:**
  - `led_out` = 0.
  - `tog` = 0.
  - `key_db` = all 1 (released); synchroniser flops = 1; debounce counters = 0.
  - Prescaler = 0; `phase` = 0; `chase` = 1 (bit 0).
- **Reset mid-operation:** all state clears immediately on `rst_n` falling, with no clock required. Operation resumes on the first edge after `rst_n` rises.
- **Key latency:**
  - Edge 1 is the first edge sampling the new `key_in` level.
  - `s` is valid at edge 2.
  - `key_db` changes, and `tog` flips, at edge 2+DEBOUNCE_CYC.
  - `led_out` reflects the change at edge 3+DEBOUNCE_CYC.
- **Glitches:** a glitch shorter than DEBOUNCE_CYC clocks at `s` produces no change.
- **Data latency:** `a`, `b` and `mode` reach `led_out` one edge after sampling.
- **Ticks:** after reset, the first `tick` occurs at edge BLINK_DIV. `phase` and `chase` update on that edge, and `led_out` follows one edge later.

## Configuration
- `LED_BLINK_EN` defined:
  - Prescaler, `phase` and `chase` are built.
  - All four modes behave as described above.
- `LED_BLINK_EN` undefined:
  - Prescaler, `phase` and `chase` are not instantiated.
  - Modes 2 and 3 behave exactly as mode 1 (`led_out = tog`).
  - `BLINK_DIV` is ignored.
  - Key and logic paths are unchanged.

## Test plan
All scenarios use CH=4, DEBOUNCE_CYC=4, BLINK_DIV=8.
- **Reset and logic:** hold `rst_n`=0 → `led_out`=0000. Release, mode=0, `a`=0011, `b`=0101, `key_in`=0000 held → `led_out`=0110 from edge 7 onward; `key_in`=1111 → 0000 within 7 edges.
- **Debounce reject/accept:** mode=1, pulse `key_in[1]`=0 for 3 clocks → `led_out` stays 0000. Hold it 0 for 10 clocks → `led_out`=0010 at edge 7 after the first sample. Release and press again → 0000.
- **Simultaneous presses:** press keys 0 and 3 in the same cycle in mode 1 → `led_out`=1001 on a single edge.
- **Blink:** `tog`=0010, mode=2 → `led_out` alternates 0000/0010 with period 16 clocks; phase transitions are 8 clocks apart.
- **Chase and wrap:** mode=3 → `led_out` steps 0001→0010→0100→1000→0001 every 8 clocks. Switch to mode 1 and back → the chase position is preserved.
- **Async reset mid-run and macro off:**
  - With `tog`=1010 and the prescaler mid-count, drop `rst_n` between edges → `led_out`=0000 before the next edge, and `tog` is cleared.
  - Rebuilt without `LED_BLINK_EN`, with mode=2 and mode=3 → `led_out` equals `tog` and stays steady.
